uart_io: RTL and testbench
==========================

UART_IO -- requirements
Module: uart_io

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 8'h10, meaning the first of four consecutive bus addresses decoded by the block.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port din  input  8  CPU write data.
REQ-005 SHALL provide port address  input  8  CPU bus address.
REQ-006 SHALL provide port w_en  input  1  write strobe, one cycle per access.
REQ-007 SHALL provide port r_en  input  1  read strobe, one cycle per access.
REQ-008 SHALL provide port dout  output  8  registered read data, valid the cycle after r_en.
REQ-009 SHALL provide port rx  input  1  serial receive line, asynchronous to clk.
REQ-010 SHALL provide port tx  output  1  serial transmit line, idle high.
REQ-011 SHALL provide port rx_irq  output  1  high while at least one received byte is unread.

Function
REQ-012 SHALL decode only the four addresses BASE_ADDR..BASE_ADDR+3; other addresses leave dout and all state unchanged.
REQ-013 SHALL map the registers as follows: +0 DATA (write: TX byte; read: pop RX byte), +1 STATUS (read only), +2 DIV[7:0], +3 DIV[15:8].
REQ-014 SHALL set STATUS bits as: [0] tx_busy, [1] rx_valid, [2] rx_overrun, [3] frame_err, [7:4] zero.
REQ-015 SHALL clear rx_overrun and frame_err on a STATUS read, with dout returning the pre-clear values.
REQ-016 SHALL use one bit period of DIV+1 clocks; DIV=0 gives 1 clock per bit; DIV writes take effect at the next frame start.
REQ-017 SHALL transmit 8N1 frames, LSB first: start (0), 8 data bits, stop (1), each one bit period long.
REQ-018 SHALL drive the start bit beginning the cycle after an accepted DATA write and assert tx_busy that same cycle.
REQ-019 SHALL deassert tx_busy at the end of the stop bit, 10*(DIV+1) clocks after it was asserted.
REQ-020 SHALL ignore a DATA write while tx_busy is 1, leaving the frame in flight unaltered.
REQ-021 SHALL pass rx through a two-flop synchronizer before any use.
REQ-022 SHALL implement the RX state machine IDLE -> START -> DATA -> STOP -> IDLE.
REQ-023 SHALL move from IDLE to START on a synchronized low level.
REQ-024 SHALL re-check the line (DIV+1)/2 clocks after entering START, moving to DATA if low and returning to IDLE (glitch) if high.
REQ-025 SHALL in DATA sample one bit every DIV+1 clocks, eight samples, LSB first.
REQ-026 SHALL sample the stop bit in STOP; a 1 stores the byte, a 0 discards it and sets frame_err.
REQ-027 SHALL drop a completed byte when RX storage is full and set rx_overrun.
REQ-028 SHALL return 8'h00 for a DATA read when storage is empty, with no state change.
REQ-029 SHALL perform a store and a pop that fall in the same cycle both, with no overrun.
REQ-030 SHALL drive rx_irq equal to STATUS[1], combinationally from state.

Reset
REQ-031 SHALL on rst_n low, asynchronously set: dout=8'h00, tx=1, rx_irq=0, DIV=16'd103, STATUS=0, RX storage empty, both state machines to IDLE, and synchronizer flops to 1.
REQ-032 SHALL abort any frame in flight on reset, without emitting a partial byte after release.

Configuration
REQ-033 SHALL, when macro UART_RX_FIFO_EN is defined, buffer RX bytes in a 4-entry FIFO (overrun on the fifth unread byte).
REQ-034 SHALL, when UART_RX_FIFO_EN is undefined, use a single holding register (overrun on the second unread byte).
REQ-035 SHALL keep all other behaviour identical with and without the macro.

Verification
REQ-036 SHALL cover TX timing: DIV=3, write 0x55 to DATA -> tx reads 0,1,0,1,0,1,0,1,0,1, each for 4 clocks; tx_busy is high for 40 clocks.
REQ-037 SHALL cover the busy write: write 0xA3 then 0xFF two cycles later -> only 0xA3 is transmitted; a STATUS read during the frame returns 0x01.
REQ-038 SHALL cover RX receive: DIV=3, drive 0xC4 at 4 clocks/bit on rx -> rx_irq=1; a DATA read returns 0xC4; rx_irq then returns to 0.
REQ-039 SHALL cover framing error: drive a frame with stop=0 -> rx_valid stays 0; STATUS reads 0x08, then 0x00 on the next read.
REQ-040 SHALL cover overrun: send 2 bytes without the macro (5 with it) without reading -> STATUS[2]=1; the first byte(s) are preserved.
REQ-041 SHALL cover reset mid-frame: pulse rst_n low mid-TX and mid-RX -> tx=1 immediately, DIV reads 103, no byte is stored.

Source files
------------

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART: DATA/STATUS/DIV registers, TX serializer, RX deserializer.
// Define UART_RX_FIFO_EN to buffer received bytes in a 4-entry FIFO instead of one holding register.
`timescale 1ns/1ps
module uart_io #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       rx_irq
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [7:0]  w_off;
  logic        w_hit;
  logic        w_wr_data, w_rd_data, w_rd_stat;
  logic [15:0] r_div;

  logic        r_tx_busy;
  logic [7:0]  r_tx_sh;
  logic [3:0]  r_tx_bit;
  logic [15:0] r_tx_cnt, r_tx_div;

  logic        r_rx_s1, r_rx_s2;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [15:0] w_half;
  logic        w_half_hit;
  logic [7:0]  r_rx_sh;
  logic [2:0]  r_rx_bit;
  logic        r_rx_done, r_rx_ferr;

  logic        r_ovr, r_ferr;
  logic        w_rx_valid, w_full, w_pop, w_store, w_drop;
  logic [7:0]  w_rd_byte;

  // Offset arithmetic handles any BASE_ADDR, including windows that wrap past 8'hFF.
  assign w_off     = address - BASE_ADDR;
  assign w_hit     = (w_off[7:2] == 6'd0);
  assign w_wr_data = w_en & w_hit & (w_off[1:0] == 2'd0);
  assign w_rd_data = r_en & w_hit & (w_off[1:0] == 2'd0);
  assign w_rd_stat = r_en & w_hit & (w_off[1:0] == 2'd1);

  assign w_pop   = w_rd_data & w_rx_valid;
  assign w_store = r_rx_done & (~w_full | w_pop);
  assign w_drop  = r_rx_done & w_full & ~w_pop;
  assign rx_irq  = w_rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 16'd103;
      dout  <= 8'h00;
    end else begin
      if (w_en && w_hit && w_off[1:0] == 2'd2) r_div[7:0]  <= din;
      if (w_en && w_hit && w_off[1:0] == 2'd3) r_div[15:8] <= din;
      if (r_en && w_hit) begin
        case (w_off[1:0])
          2'd0:    dout <= w_rx_valid ? w_rd_byte : 8'h00;
          2'd1:    dout <= {4'h0, r_ferr, r_ovr, w_rx_valid, r_tx_busy};
          2'd2:    dout <= r_div[7:0];
          default: dout <= r_div[15:8];
        endcase
      end
    end
  end

  // Error flags: a STATUS read clears them, but a new event in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_rd_stat) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_drop)    r_ovr  <= 1'b1;
      if (r_rx_ferr) r_ferr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_sh   <= 8'h00;
      r_tx_bit  <= 4'd0;
      r_tx_cnt  <= 16'd0;
      r_tx_div  <= 16'd0;
    end else if (!r_tx_busy) begin
      if (w_wr_data) begin
        tx        <= 1'b0;
        r_tx_busy <= 1'b1;
        r_tx_sh   <= din;
        r_tx_bit  <= 4'd0;
        r_tx_cnt  <= 16'd0;
        r_tx_div  <= r_div;
      end
    end else if (r_tx_cnt == r_tx_div) begin
      r_tx_cnt <= 16'd0;
      r_tx_bit <= r_tx_bit + 4'd1;
      if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
      end else if (r_tx_bit == 4'd8) begin
        tx <= 1'b1;
      end else begin
        tx      <= r_tx_sh[0];
        r_tx_sh <= {1'b0, r_tx_sh[7:1]};
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_half     = 16'(({1'b0, r_rx_div} + 17'd1) >> 1);
  assign w_half_hit = ({1'b0, r_rx_cnt} + 17'd1) >= {1'b0, w_half};

  // Completed bytes and framing errors leave as one-cycle registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_div   <= 16'd0;
      r_rx_sh    <= 8'h00;
      r_rx_bit   <= 3'd0;
      r_rx_done  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= r_div;
          end
        end
        RX_START: begin
          if (w_half_hit) begin
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == r_rx_div) begin
            r_rx_cnt <= 16'd0;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == r_rx_div) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) r_rx_done <= 1'b1;
            else         r_rx_ferr <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;

  assign w_rx_valid = (r_cnt != 3'd0);
  assign w_full     = (r_cnt == 3'd4);
  assign w_rd_byte  = r_fifo[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_store) r_wp <= r_wp + 2'd1;
      if (w_pop)   r_rp <= r_rp + 2'd1;
      case ({w_store, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_fifo[r_wp] <= r_rx_sh;
  end
`else
  logic [7:0] r_hold;
  logic       r_valid;

  assign w_rx_valid = r_valid;
  assign w_full     = r_valid;
  assign w_rd_byte  = r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_valid <= 1'b0;
    else if (w_store) r_valid <= 1'b1;
    else if (w_pop)   r_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_store) r_hold <= r_rx_sh;
  end
`endif

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io: register access, TX framing/timing, RX receive, errors, reset abort.
`timescale 1ns/1ps
module tb_uart_io;

  logic       clk, rst_n;
  logic [7:0] din, address;
  logic       w_en, r_en;
  logic [7:0] dout;
  logic       rx, tx, rx_irq;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  uart_io #(.BASE_ADDR(8'h10)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .address(address),
    .w_en(w_en), .r_en(r_en), .dout(dout),
    .rx(rx), .tx(tx), .rx_irq(rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    address = a; din = d; w_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    address = a; r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    d = dout;
  endtask

  // One bit every 40 ns = 4 clocks, matching DIV=3.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0; #40;
    for (int k = 0; k < 8; k++) begin
      rx = b[k]; #40;
    end
    rx = stop; #40;
    rx = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0]  rd;
    logic [39:0] tx_obs, tx_exp;
    logic [9:0]  pat;
    logic [8:0]  fr_obs;
    logic [7:0]  b;
    int          t0;

    rst_n = 1'b0; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_tx", tx, 1'b1);
    check("reset_irq", rx_irq, 1'b0);
    check("reset_dout", dout, 8'h00);
    bus_read(8'h11, rd); check("reset_status", rd, 8'h00);
    bus_read(8'h12, rd); check("reset_div_lo", rd, 8'h67);
    bus_read(8'h13, rd); check("reset_div_hi", rd, 8'h00);

    bus_write(8'h12, 8'h03);
    bus_write(8'h13, 8'h00);
    bus_read(8'h12, rd); check("div_lo_write", rd, 8'h03);
    bus_read(8'h14, rd); check("decode_miss_keeps_dout", dout, 8'h03);

    // TX 0x55: 0,1,0,1,0,1,0,1,0,1 with 4 clocks per bit
    pat = 10'h2AA;
    for (int i = 0; i < 40; i++) tx_exp[i] = pat[i / 4];
    bus_write(8'h10, 8'h55);
    for (int i = 0; i < 40; i++) begin
      tx_obs[i] = tx;
      if (i < 39) begin
        @(posedge clk); #1;
      end
    end
    check("tx_55_waveform", tx_obs, tx_exp);
    address = 8'h11; r_en = 1'b1;
    @(posedge clk); #1;
    check("tx_busy_clock40", dout, 8'h01);
    @(posedge clk); #1;
    check("tx_busy_clock41", dout, 8'h00);
    r_en = 1'b0;

    // Write during busy is ignored
    bus_write(8'h10, 8'hA3);
    t0 = cyc;
    bus_write(8'h10, 8'hFF);
    bus_read(8'h11, rd); check("status_during_tx", rd, 8'h01);
    for (int k = 1; k < 10; k++) begin
      wait_cyc(t0 + 4 * k + 2);
      fr_obs[k - 1] = tx;
    end
    check("tx_a3_frame", fr_obs, 9'h1A3);
    wait_cyc(t0 + 46);
    check("no_second_frame_tx", tx, 1'b1);
    bus_read(8'h11, rd); check("idle_after_busy_write", rd, 8'h00);

    // RX receive 0xC4
    send_rx(8'hC4, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("rx_irq_set", rx_irq, 1'b1);
    bus_read(8'h11, rd); check("rx_status_valid", rd, 8'h02);
    bus_read(8'h10, rd); check("rx_data_c4", rd, 8'hC4);
    check("rx_irq_cleared", rx_irq, 1'b0);
    bus_read(8'h10, rd); check("rx_empty_read", rd, 8'h00);

    // Framing error
    send_rx(8'h5A, 1'b0);
    repeat (6) @(posedge clk); #1;
    check("ferr_no_valid", rx_irq, 1'b0);
    bus_read(8'h11, rd); check("ferr_status", rd, 8'h08);
    bus_read(8'h11, rd); check("ferr_cleared", rd, 8'h00);

    // Overrun: one byte more than storage holds
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(17 * (i + 1));
      send_rx(b, 1'b1);
      #20;
    end
    repeat (4) @(posedge clk); #1;
    bus_read(8'h11, rd); check("ovr_status", rd, 8'h06);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(8'h10, rd);
      check("ovr_kept_byte", rd, 8'(17 * (i + 1)));
    end
    bus_read(8'h11, rd); check("ovr_cleared", rd, 8'h00);

    // Reset during a TX frame and an RX frame
    bus_write(8'h10, 8'h00);
    rx = 1'b0;
    repeat (12) @(posedge clk); #1;
    check("mid_frame_tx_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("reset_async_tx", tx, 1'b1);
    rx = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    check("post_reset_tx_idle", tx, 1'b1);
    check("post_reset_irq", rx_irq, 1'b0);
    bus_read(8'h11, rd); check("post_reset_status", rd, 8'h00);
    bus_read(8'h12, rd); check("post_reset_div_lo", rd, 8'h67);
    bus_read(8'h10, rd); check("post_reset_no_byte", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
